// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive buffer.
// Holds the default byte width, the stored entry layout and the status bit
// indices that the APB register map also uses.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W = 8;

  // One stored FIFO entry: the frame-error flag sits above the data byte.
  typedef struct packed {
    logic                   ferr;
    logic [UART_DATA_W-1:0] data;
  } uart_entry_t;

  // Bit positions in the APB status register.
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_TO    = 3;

  // A programmed threshold of 0 behaves as 1, so irq never fires on an empty FIFO.
  function automatic int eff_thresh(input int t);
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the RX FIFO: one synchronous write port and one
// asynchronous read port. The array has no reset; the top level masks the read
// data while the FIFO is empty.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the incoming entry on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX byte FIFO with fill level, sticky overrun and a registered interrupt.
// Reads are first-word-fall-through; a pushed byte is visible one cycle later.
// Optional idle timeout is enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = UART_DATA_W,
  parameter int TO_BITS = 32
) (
  input  logic                   pclk,
  input  logic                   prst,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_frame_err,
  input  logic                   rx_valid,
  input  logic                   baud_tick,
  input  logic                   rd_en,
  input  logic [$clog2(DEPTH):0] thresh,
  input  logic                   clr_ovr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_ferr,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  output logic                   irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          overrun_q, overrun_d;
  logic          irq_q, irq_d;
  logic          timeout_d;
  logic          push, pop;
  logic [EW-1:0] mem_rdata;

  uart_fifo_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk_i   (pclk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({rx_frame_err, rx_data}),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Next-state for pointers, occupancy, flags and interrupt.
  always_comb begin
    // A full FIFO still accepts a byte when the same cycle pops one.
    push      = rx_valid & (~full_q | rd_en);
    pop       = rd_en & ~empty_q;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    empty_d   = (count_d == '0);
    full_d    = (count_d == CW'(DEPTH));
    // A new drop wins over a same-cycle clear.
    overrun_d = (rx_valid & full_q & ~rd_en) | (overrun_q & ~clr_ovr);
    irq_d     = (int'(count_d) >= eff_thresh(int'(thresh))) | overrun_d | timeout_d;
  end

  // State registers.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TCW = $clog2(TO_BITS + 1);

  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q, to_set;

  // Count idle baud ticks while data sits unread; saturate at TO_BITS.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_set   = 1'b0;
    if (push | pop | empty_q) begin
      to_cnt_d = '0;
    end else if (baud_tick && (to_cnt_q < TCW'(TO_BITS))) begin
      to_cnt_d = to_cnt_q + 1'b1;
      to_set   = (to_cnt_d == TCW'(TO_BITS));
    end
    timeout_d = pop ? 1'b0 : (timeout_q | to_set);
  end

  // Timeout counter and sticky flag.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  localparam int unused_to_bits = TO_BITS;
  logic          unused_baud_tick;

  assign unused_baud_tick = baud_tick;
  assign timeout_d        = 1'b0;
`endif

  assign rd_data = empty_q ? '0   : mem_rdata[DATA_W-1:0];
  assign rd_ferr = empty_q ? 1'b0 : mem_rdata[DATA_W];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule
